// File: rtl/picorv32_mem_io_slave.sv
// rtl/picorv32_mem_io_slave.sv - PicoRV32 native-bus slave: RAM, GPIO out/in, wait states
// Optional cycle counter at GPIO_BASE+8 enabled by macro PICORV32_MEMIO_CYCLE_COUNTER_EN.
module picorv32_mem_io_slave #(
  parameter int          MEM_WORDS     = 128,
  parameter              MEM_INIT_FILE = "firmware.hex",
  parameter int          MEM_WAIT      = 0,
  parameter logic [31:0] GPIO_BASE     = 32'h1000_0000,
  parameter int          GPIO_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  bus_error
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [3:0]  WAIT_LAST = 4'(MEM_WAIT);
  localparam logic [29:0] W_OUT     = GPIO_BASE[31:2];
  localparam logic [29:0] W_IN      = W_OUT + 30'd1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next;

  logic [31:0]           r_mem [MEM_WORDS];
  logic [29:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [3:0]            r_count;
  logic                  r_post_resp;
  logic [31:0]           r_rdata;
  logic [GPIO_WIDTH-1:0] r_gpio_out, r_sync1, r_sync2;
  logic                  w_ram_hit, w_out_hit, w_in_hit, w_cyc_hit, w_mapped;
  logic [31:0]           w_read_val;
  logic [AW-1:0]         w_idx;
  logic                  w_unused_ok;

  assign w_idx       = r_addr[AW-1:0];
  assign w_ram_hit   = (r_addr[29:AW] == '0);
  assign w_out_hit   = (r_addr == W_OUT);
  assign w_in_hit    = (r_addr == W_IN);
  assign w_mapped    = w_ram_hit | w_out_hit | w_in_hit | w_cyc_hit;
  assign w_unused_ok = &{1'b0, mem_addr[1:0]};
  assign mem_rdata   = r_rdata;
  assign gpio_out    = r_gpio_out;

`ifdef PICORV32_MEMIO_CYCLE_COUNTER_EN
  localparam logic [29:0] W_CYC = W_OUT + 30'd2;
  logic [31:0] r_cycles;
  assign w_cyc_hit = (r_addr == W_CYC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycles <= '0;
    else       r_cycles <= r_cycles + 32'd1;
  end
`else
  assign w_cyc_hit = 1'b0;
`endif

  always_comb begin
    w_read_val = '0;
    if (w_ram_hit)      w_read_val = r_mem[w_idx];
    else if (w_out_hit) w_read_val = 32'(r_gpio_out);
    else if (w_in_hit)  w_read_val = 32'(r_sync2);
`ifdef PICORV32_MEMIO_CYCLE_COUNTER_EN
    else if (w_cyc_hit) w_read_val = r_cycles;
`endif
  end

  // The IDLE cycle right after RESP never accepts a request, even with mem_valid still high.
  always_comb begin
    w_next    = r_state;
    mem_ready = 1'b0;
    bus_error = 1'b0;
    case (r_state)
      S_IDLE: if (mem_valid && !r_post_resp) w_next = S_WAIT;
      S_WAIT: if (r_count == WAIT_LAST) w_next = S_RESP;
      S_RESP: begin
        mem_ready = 1'b1;
        bus_error = ~w_mapped;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_count     <= '0;
      r_post_resp <= 1'b0;
      r_rdata     <= '0;
      r_gpio_out  <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
    end else begin
      r_state     <= w_next;
      r_post_resp <= (r_state == S_RESP);
      r_sync1     <= gpio_in;
      r_sync2     <= r_sync1;
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (w_next == S_WAIT) begin
            r_addr  <= mem_addr[31:2];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
          end
        end
        S_WAIT: begin
          r_count <= r_count + 4'd1;
          if (w_next == S_RESP) r_rdata <= w_read_val;
        end
        S_RESP: begin
          r_rdata <= '0;
          if (w_out_hit)
            for (int i = 0; i < GPIO_WIDTH; i++)
              if (r_wstrb[i/8]) r_gpio_out[i] <= r_wdata[i];
        end
        default: r_count <= '0;
      endcase
    end
  end

  // RAM is never reset; the async reset drops the FSM out of RESP so no write lands.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && w_ram_hit)
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_picorv32_mem_io_slave.sv
// tb/tb_picorv32_mem_io_slave.sv - bench for picorv32_mem_io_slave (MEM_WAIT 0 and 3 instances)
module tb_picorv32_mem_io_slave;
  localparam int          NI = 2;
  localparam logic [31:0] GB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        valid [NI];
  logic        ready [NI];
  logic        berr  [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic [3:0]  wstrb [NI];
  logic [7:0]  gpo   [NI];
  logic [7:0]  gpi   [NI];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Behavioural model state
  logic [31:0] m_ram [NI][128];
  logic [7:0]  m_gpo [NI];

  // Outstanding transaction per instance
  logic        p_pending [NI];
  logic        p_done    [NI];
  logic        p_exp_err [NI];
  logic        p_exp_chk [NI];
  logic        p_obs_err [NI];
  int          p_exp_cyc [NI];
  int          p_seen    [NI];
  logic [31:0] p_exp_rdata [NI];
  logic [31:0] p_obs_rdata [NI];
  logic [31:0] p_addr  [NI];
  logic [31:0] p_wdata [NI];
  logic [3:0]  p_wstrb [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  picorv32_mem_io_slave #(.MEM_WORDS(128), .MEM_INIT_FILE(""), .MEM_WAIT(0),
    .GPIO_BASE(GB), .GPIO_WIDTH(8)) u_dut0 (
    .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_ready(ready[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]),
    .gpio_out(gpo[0]), .gpio_in(gpi[0]), .bus_error(berr[0]));

  picorv32_mem_io_slave #(.MEM_WORDS(128), .MEM_INIT_FILE(""), .MEM_WAIT(3),
    .GPIO_BASE(GB), .GPIO_WIDTH(8)) u_dut1 (
    .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_ready(ready[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]),
    .gpio_out(gpo[1]), .gpio_in(gpi[1]), .bus_error(berr[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic logic m_mapped(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    if (wa < 32'd512) return 1'b1;
    if (wa == GB || wa == GB + 32'd4) return 1'b1;
`ifdef PICORV32_MEMIO_CYCLE_COUNTER_EN
    if (wa == GB + 32'd8) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int i, input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    if (wa < 32'd512)       return m_ram[i][wa[8:2]];
    if (wa == GB)           return {24'h0, m_gpo[i]};
    if (wa == GB + 32'd4)   return {24'h0, gpi[i]};
    return 32'h0;
  endfunction

  function automatic void m_write(input int i, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s);
    logic [31:0] wa = {a[31:2], 2'b00};
    if (wa < 32'd512) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_ram[i][wa[8:2]][8*b +: 8] = d[8*b +: 8];
    end else if (wa == GB && s[0]) begin
      m_gpo[i] = d[7:0];
    end
  endfunction

  // Single compare process: every cycle, ready/bus_error/gpio_out against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ready[i] === 1'b1 && p_seen[i] < 0) p_seen[i] = cyc;
      chk($sformatf("gpio_out%0d", i), 32'(gpo[i]), 32'(m_gpo[i]));
      if (p_pending[i] && cyc == p_exp_cyc[i]) begin
        chk($sformatf("ready%0d", i), 32'(ready[i]), 32'd1);
        chk($sformatf("bus_error%0d", i), 32'(berr[i]), 32'(p_exp_err[i]));
        if (p_exp_chk[i]) chk($sformatf("rdata%0d@%h", i, p_addr[i]), rdata[i], p_exp_rdata[i]);
        p_obs_rdata[i] = rdata[i];
        p_obs_err[i]   = berr[i];
        m_write(i, p_addr[i], p_wdata[i], p_wstrb[i]);
        p_pending[i] = 1'b0;
        p_done[i]    = 1'b1;
      end else begin
        chk($sformatf("idle_ready%0d", i), 32'(ready[i]), 32'd0);
        chk($sformatf("idle_bus_error%0d", i), 32'(berr[i]), 32'd0);
      end
    end
  end

  task automatic xfer(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold, output logic [31:0] rd,
                      output logic err, output int lat, output int start);
    int n;
    @(posedge clk); #2;
    addr[i] = a; wdata[i] = d; wstrb[i] = s; valid[i] = 1'b1;
    start          = cyc;
    p_addr[i]      = a;
    p_wdata[i]     = d;
    p_wstrb[i]     = s;
    p_exp_cyc[i]   = cyc + 2 + wait_of(i);
    p_exp_err[i]   = !m_mapped(a);
    p_exp_rdata[i] = m_read(i, a);
    p_exp_chk[i]   = (s == 4'h0) && !(m_mapped(a) && {a[31:2], 2'b00} == GB + 32'd8);
    p_seen[i]      = -1;
    p_done[i]      = 1'b0;
    p_pending[i]   = 1'b1;
    n = 0;
    while (!p_done[i] && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (!p_done[i]) begin
      tests++; fails++;
      $display("FAIL timeout%0d: no completion for %h", i, a);
      p_pending[i] = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
    end
    valid[i] = 1'b0; wstrb[i] = 4'h0;
    rd  = p_obs_rdata[i];
    err = p_obs_err[i];
    lat = (p_seen[i] >= 0) ? p_seen[i] - start : -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, rd2;
    logic        err;
    int          lat, s1, s2;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
      gpi[i] = 8'h00; m_gpo[i] = 8'h00; p_pending[i] = 1'b0; p_done[i] = 1'b0;
      p_seen[i] = -1; p_obs_rdata[i] = '0; p_obs_err[i] = 1'b0;
      for (int w = 0; w < 128; w++) m_ram[i][w] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready[0]), 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_gpio", 32'(gpo[1]), 32'd0);
    chk("reset_berr", 32'(berr[1]), 32'd0);

    // RAM read/write, latency with zero wait states
    xfer(0, 32'h0, 32'hDEADBEEF, 4'hF, 0, rd, err, lat, s1);
    xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_berr", 32'(err), 32'd0);
    xfer(0, 32'h10, 32'h11223344, 4'hF, 0, rd, err, lat, s1);
    xfer(0, 32'h10, 32'h00AA0000, 4'b0100, 0, rd, err, lat, s1);
    xfer(0, 32'h12, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t2_partial", rd, 32'h11AA3344);

    // GPIO out write truncation and readback; mandatory idle with valid held
    xfer(0, GB, 32'hFFFF_FFA5, 4'hF, 1, rd, err, lat, s1);
    chk("t3_gpio_out", 32'(gpo[0]), 32'h0000_00A5);
    xfer(0, GB, 32'h0, 4'h0, 1, rd, err, lat, s1);
    chk("t3_readback", rd, 32'h0000_00A5);
    xfer(0, GB, 32'h0000_5A00, 4'b0010, 0, rd, err, lat, s1);
    chk("gpio_hi_strobe", 32'(gpo[0]), 32'h0000_00A5);

    // Synchronised input, both wait configurations
    gpi[0] = 8'h3C; gpi[1] = 8'h3C;
    repeat (3) @(posedge clk);
    xfer(0, GB + 32'd4, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t4_gpio_in", rd, 32'h0000_003C);
    xfer(1, GB + 32'd4, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t4_gpio_in_w3", rd, 32'h0000_003C);
    chk("t4_latency_w3", 32'(lat), 32'd5);
    xfer(0, GB + 32'd4, 32'hFFFF_FFFF, 4'hF, 0, rd, err, lat, s1);
    chk("in_write_berr", 32'(err), 32'd0);

    // Unmapped and RAM boundary
    xfer(0, 32'h2000_0000, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t5_rdata", rd, 32'h0);
    chk("t5_berr", 32'(err), 32'd1);
    chk("t5_latency", 32'(lat), 32'd2);
    xfer(0, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 0, rd, err, lat, s1);
    xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t5_ram_kept", rd, 32'hDEADBEEF);
    xfer(0, 32'h1FC, 32'hCAFE_F00D, 4'hF, 0, rd, err, lat, s1);
    xfer(0, 32'h1FC, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("ram_last", rd, 32'hCAFE_F00D);
    xfer(0, 32'h200, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("ram_past_end_berr", 32'(err), 32'd1);

    // Reset during WAIT of a GPIO write
    xfer(1, GB, 32'h11, 4'hF, 0, rd, err, lat, s1);
    chk("w3_gpio_pre", 32'(gpo[1]), 32'h11);
    @(posedge clk); #2;
    addr[1] = GB; wdata[1] = 32'h5A; wstrb[1] = 4'hF; valid[1] = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
    end
    rst[1] = 1'b1; valid[1] = 1'b0; wstrb[1] = 4'h0; m_gpo[1] = 8'h00;
    #1;
    chk("t6_gpio_reset", 32'(gpo[1]), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst[1] = 1'b0;
    repeat (6) @(posedge clk);
    xfer(1, GB, 32'h77, 4'hF, 0, rd, err, lat, s1);
    xfer(1, GB, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("t6_after_reset", rd, 32'h77);

`ifdef PICORV32_MEMIO_CYCLE_COUNTER_EN
    xfer(0, GB + 32'd8, 32'h0, 4'h0, 0, rd, err, lat, s1);
    repeat (10) @(posedge clk);
    xfer(0, GB + 32'd8, 32'h0, 4'h0, 0, rd2, err, lat, s2);
    chk("cycles_diff", rd2 - rd, 32'(s2 - s1));
    chk("cycles_diff_lit", rd2 - rd, 32'd14);
`else
    xfer(0, GB + 32'd8, 32'h0, 4'h0, 0, rd, err, lat, s1);
    chk("cycles_off_rdata", rd, 32'h0);
    chk("cycles_off_berr", 32'(err), 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
